// File: rtl/cd_seq_mult_pkg.sv
// cd_pkg: state encoding and width/mask helpers shared by the carry-disregard multiplier family.
package cd_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} cd_state_e;
    localparam int CD_MAX_W = 64;
    function automatic int cd_res_w(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction
    function automatic logic [CD_MAX_W-1:0] cd_mask(input int l, input int w);
        logic [CD_MAX_W-1:0] m;
        m = '0;
        for (int c = 0; c < CD_MAX_W; c++) m[c] = (c < l) && (c < w);
        return m;
    endfunction
endpackage

// File: rtl/cd_seq_mult_if.sv
// cd_seq_mult_if: operand/result valid-ready handshake bundle for cd_seq_mult.
interface cd_seq_mult_if #(parameter int A_W = 8, parameter int B_W = 4);
    import cd_pkg::*;
    localparam int R_W = cd_res_w(A_W, B_W);
    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic           approx_en;
    logic           out_valid;
    logic           out_ready;
    logic [R_W-1:0] r;
    logic           busy;
    modport master (output in_valid, a, b, approx_en, out_ready, input in_ready, out_valid, r, busy);
    modport slave  (input in_valid, a, b, approx_en, out_ready, output in_ready, out_valid, r, busy);
endinterface

// File: rtl/cd_seq_mult_row_acc.sv
// cd_row_acc: one accumulation step -- carry-free XOR below column L, exact add at and above it.
module cd_row_acc import cd_pkg::*; #(parameter int W = 12) (
    input  logic [W-1:0] i_acc,
    input  logic [W-1:0] i_pp,
    input  logic [7:0]   i_l,
    output logic [W-1:0] o_acc
);
    logic [W-1:0] w_mask;
    assign w_mask = W'(cd_mask(int'(i_l), W));
    // high operands have zero low bits, so their sum never disturbs the XOR columns
    assign o_acc = ((i_acc & ~w_mask) + (i_pp & ~w_mask)) | ((i_acc ^ i_pp) & w_mask);
endmodule

// File: rtl/cd_seq_mult.sv
// cd_seq_mult: sequential carry-disregard approximate multiplier, one B row per clock.
module cd_seq_mult import cd_pkg::*; #(
    parameter int A_W         = 8,
    parameter int B_W         = 4,
    parameter int APPROX_COLS = 3
) (
    input logic           clk,
    input logic           rst,
    cd_seq_mult_if.slave  io_bus
);
    localparam int R_W = cd_res_w(A_W, B_W);
    localparam int C_W = B_W > 1 ? $clog2(B_W) : 1;
    cd_state_e      r_state, w_next;
    logic [A_W-1:0] r_a;
    logic [B_W-1:0] r_b;
    logic           r_approx;
    logic [C_W-1:0] r_row;
    logic [R_W-1:0] r_acc, r_r, w_pp, w_acc;
    logic           w_last, w_accept;
    assign w_last   = r_row == C_W'(B_W - 1);
    assign w_accept = r_state == IDLE && io_bus.in_valid;
    assign w_pp     = r_b[r_row] ? R_W'(r_a) << r_row : '0;
    cd_row_acc #(.W(R_W)) u_row_acc (
        .i_acc (r_acc),
        .i_pp  (w_pp),
        .i_l   (r_approx ? 8'(APPROX_COLS) : 8'd0),
        .o_acc (w_acc)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    always_comb begin
        w_next = r_state;
        if (w_accept) w_next = RUN;
        else if (r_state == RUN && w_last) w_next = DONE;
        else if (r_state == DONE && io_bus.out_ready) w_next = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_approx <= 1'b0;
            r_row    <= '0;
            r_acc    <= '0;
            r_r      <= '0;
        end else if (w_accept) begin
            r_a      <= io_bus.a;
            r_b      <= io_bus.b;
            r_approx <= io_bus.approx_en;
            r_row    <= '0;
            r_acc    <= '0;
        end else if (r_state == RUN) begin
            r_acc <= w_acc;
            r_row <= r_row + 1'b1;
            if (w_last) r_r <= w_acc;
        end
    end
    assign io_bus.in_ready  = r_state == IDLE && !rst;
    assign io_bus.out_valid = r_state == DONE;
    assign io_bus.busy      = r_state == RUN;
    assign io_bus.r         = r_r;
endmodule

// File: tb/tb_cd_seq_mult.sv
// tb_cd_seq_mult: directed and randomised checks of cd_seq_mult (A_W=8, B_W=4, APPROX_COLS=3).
module tb_cd_seq_mult;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    cd_seq_mult_if #(.A_W(8), .B_W(4)) bus ();
    cd_seq_mult #(.A_W(8), .B_W(4), .APPROX_COLS(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus.slave)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask
    function automatic logic [11:0] gold(input logic [7:0] a, input logic [3:0] b, input int l);
        logic [11:0] hi, lo;
        hi = '0;
        lo = '0;
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 4; k++)
                if (a[i] && b[k]) begin
                    if (i + k < l) lo[i+k] = ~lo[i+k];
                    else hi = hi + (12'd1 << (i + k));
                end
        return hi | lo;
    endfunction
    task automatic run_op(input logic [7:0] a, input logic [3:0] b, input logic ap,
                          input logic [11:0] exp, input string tag, input int hold, input logic early);
        int n;
        bus.a = a;
        bus.b = b;
        bus.approx_en = ap;
        bus.in_valid = 1'b1;
        bus.out_ready = early;
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        tick;
        bus.in_valid = 1'b0;
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_in_ready_run"}, bus.in_ready, 0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick;
            n++;
        end
        chk({tag, "_latency"}, n, 4);
        chk({tag, "_r"}, bus.r, exp);
        chk({tag, "_in_ready_done"}, bus.in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = (i == 1);
            bus.a = 8'hA5;
            bus.b = 4'h9;
            tick;
            chk({tag, "_hold_valid"}, bus.out_valid, 1);
            chk({tag, "_hold_r"}, bus.r, exp);
            chk({tag, "_hold_busy"}, bus.busy, 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        chk({tag, "_retired"}, bus.out_valid, 0);
        chk({tag, "_idle_ready"}, bus.in_ready, 1);
        chk({tag, "_idle_busy"}, bus.busy, 0);
    endtask
    initial begin
        logic [7:0]  ra;
        logic [3:0]  rb;
        logic        rap, rearly;
        int          rhold;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.approx_en = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        chk("rst_r", bus.r, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        tick;
        run_op(8'hFF, 4'hF, 1'b1, 12'hEE5, "ff_apx", 0, 1'b0);
        run_op(8'hFF, 4'hF, 1'b0, 12'hEF1, "ff_exact", 0, 1'b0);
        run_op(8'h03, 4'h3, 1'b1, 12'h005, "x3_apx", 0, 1'b0);
        run_op(8'h03, 4'h3, 1'b0, 12'h009, "x3_exact", 0, 1'b0);
        run_op(8'h00, 4'hF, 1'b1, 12'h000, "zero_a", 0, 1'b0);
        run_op(8'hFF, 4'h0, 1'b0, 12'h000, "zero_b", 0, 1'b1);
        run_op(8'h03, 4'h3, 1'b1, 12'h005, "backpressure", 5, 1'b0);
        bus.a = 8'hFF;
        bus.b = 4'hF;
        bus.approx_en = 1'b1;
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        tick;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_r", bus.r, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_in_ready", bus.in_ready, 0);
        #3;
        rst = 1'b0;
        #1;
        chk("postrst_in_ready", bus.in_ready, 1);
        chk("postrst_out_valid", bus.out_valid, 0);
        run_op(8'h10, 4'h2, 1'b1, 12'h020, "postrst_op", 0, 1'b0);
        for (int t = 0; t < 400; t++) begin
            ra = 8'($urandom);
            rb = 4'($urandom);
            rap = 1'($urandom_range(0, 1));
            rhold = $urandom_range(0, 3);
            rearly = (rhold == 0) && ($urandom_range(0, 1) == 1);
            run_op(ra, rb, rap, rap ? gold(ra, rb, 3) : 12'(ra) * 12'(rb), rap ? "rnd_apx" : "rnd_exact", rhold, rearly);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cd_seq_mult.md
Name: cd_seq_mult

Overview:
- Sequential, parametrised carry-disregard approximate multiplier for unsigned operands.
- Consumes one B-operand row per clock and accumulates partial products.
- In the low APPROX_COLS columns, partial products are combined carry-free (XOR), and carries out of those columns are discarded.
- Columns at and above APPROX_COLS are summed exactly.
- Successor to the fixed 8x4 combinational approximate multipliers:
  - operand widths and approximation depth are generic;
  - exact/approximate mode is selectable per operation;
  - operands and results are exchanged over valid/ready handshakes.

Parameters:
- A_W, 8, width of multiplicand A.
- B_W, 4, width of multiplier B; also the number of accumulation cycles.
- APPROX_COLS, 3, number of LSB columns computed carry-free. Legal range is 0..A_W+B_W-1; 0 means exact.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- a  in  A_W  multiplicand.
- b  in  B_W  multiplier.
- approx_en  in  1  1 = carry-disregard result; 0 = exact product. Sampled with the operands.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- r  out  A_W+B_W  product.
- busy  out  1  high while in the RUN state.

Behaviour:
- Reset is asynchronous and active-high, and may be asserted mid-operation. It forces:
  - state to IDLE;
  - the accumulator, row counter and operand registers to 0;
  - r = 0, out_valid = 0, busy = 0, in_ready = 0 while rst is high.
- After reset deasserts, in_ready = 1 in IDLE. Any in-flight operation is lost with no output.
- FSM states:
  - IDLE: in_ready = 1. When in_valid = 1, the block latches a, b and approx_en, clears the accumulator, sets row = 0 and goes to RUN.
  - RUN: in_ready = 0, busy = 1. Each cycle it adds row j = row: pp_j = (b[j] ? a : 0) << j. When row = B_W-1, the final sum is written to r, out_valid is set, and the state goes to DONE. Otherwise row increments.
  - DONE: out_valid = 1 and r is held stable. When out_ready = 1, out_valid clears and the state goes to IDLE.
- Latency:
  - the accept cycle is followed by exactly B_W RUN cycles;
  - out_valid rises on the B_W-th edge after the accept edge;
  - out_valid is independent of operand values (no zero-row skipping).
- Throughput: one operation per B_W+2 cycles.
  - There is no back-to-back accept on the same cycle as result retirement.
  - in_ready rises in the cycle after the DONE handshake.
- Accumulation rule, with L = APPROX_COLS when approx_en = 1 and L = 0 otherwise. Let mask_lo = (1<<L)-1.
  - acc_lo_next = acc_lo XOR (pp_j & mask_lo): column-wise carry-free.
  - acc_hi_next = acc_hi + (pp_j & ~mask_lo): exact, width A_W+B_W. It never overflows because the exact product fits.
  - acc = acc_hi | acc_lo. No carry ever crosses from column L-1 into column L.
- Golden model, for each column c:
  - if c < L: bit c of r = parity of {a[i]&b[k] : i+k = c};
  - the upper part of r equals the exact sum of all partial-product bits with i+k >= L.
- Width rule: r is always A_W+B_W bits. The approximate result is never larger than the exact result.
- in_valid while not in IDLE is ignored; the operand is not captured.
- out_ready while not in DONE is ignored.
- a or b equal to 0 still takes the full B_W cycles and gives r = 0.

Decomposition:
- Shared package cd_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the localparam function for the result width;
  - the function cd_mask(L, W) that builds mask_lo.
- One combinational sub-module, cd_row_acc. It takes acc, pp_j and L and returns the next accumulator (XOR low / add high). It can be reused by future unrolled or pipelined variants.
- The FSM, counter and handshake live in cd_seq_mult.

Test Plan (defaults A_W=8, B_W=4, APPROX_COLS=3):
- a=8'hFF, b=4'hF, approx_en=1 -> r=12'hEE5 (3813), out_valid exactly 4 cycles after the accept edge. Same operands with approx_en=0 -> r=12'hEF1 (3825).
- a=8'h03, b=4'h3, approx_en=1 -> r=12'h005; approx_en=0 -> r=12'h009.
- a=8'h00, b=4'hF, approx_en=1 -> r=0 after the full 4 RUN cycles; in_ready stays 0 until the DONE handshake completes.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and r are stable. Pulse in_valid with new operands during this time -> the pulse is ignored. Then out_ready=1 -> out_valid drops and in_ready=1 on the next cycle.
- Assert rst during RUN cycle 2 -> immediately out_valid=0, r=0, busy=0. After release, in_ready=1 and a new a=8'h10, b=4'h2 with approx_en=1 -> r=12'h020.
- Randomised sweep: 10k operations with random out_ready backpressure, for APPROX_COLS=0 and APPROX_COLS=3. Compare r against the column-parity golden model; for APPROX_COLS=0, r must equal a*b.
